// File: rtl/kamus_pkg.sv
// Shared types for the kamus memory-side blocks.
// The arbiter FSM state, owner tag and latched bus request live here.
package kamus_pkg;

    localparam int KAMUS_ADDR_W = 32;
    localparam int KAMUS_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RSP
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_I,
        ARB_OWN_D
    } arb_owner_e;

    typedef struct packed {
        logic                      we;
        logic [KAMUS_DATA_W/8-1:0] be;
        logic [KAMUS_ADDR_W-1:0]   addr;
        logic [KAMUS_DATA_W-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/kamus_arb_starve_cnt.sv
// Saturating count of data wins taken while a fetch was waiting.
// at_limit tells the arbiter to let the fetch through next.
module kamus_arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] MAX = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != MAX) begin
            cnt <= cnt + W'(1);
        end
    end

    assign at_limit = (cnt == MAX);

endmodule

// File: rtl/kamus_mem_arbiter.sv
// Fetch/data arbiter for the single-ported memory bus, one
// transaction in flight, data priority with fetch anti-starvation.
module kamus_mem_arbiter
    import kamus_pkg::*;
#(
    parameter int ADDR_W       = KAMUS_ADDR_W,
    parameter int DATA_W       = KAMUS_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                i_req_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic                i_gnt_o,
    output logic                i_rvalid_o,
    output logic [DATA_W-1:0]   i_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    arb_state_e state;
    arb_owner_e owner;
    mem_req_t   lat;

    logic idle;
    logic at_limit;
    logic i_win;
    logic d_win;
    logic in_req;
    logic gnt;
    logic rsp;

    assign idle  = (state == ARB_IDLE);
    assign i_win = i_req_i && (!d_req_i || at_limit);
    assign d_win = d_req_i && !i_win;

    kamus_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .inc      (idle && d_win && i_req_i),
        .clr      (idle && i_win),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= ARB_IDLE;
            owner <= ARB_OWN_D;
            lat   <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (i_win) begin
                        owner <= ARB_OWN_I;
                        lat   <= '{we: 1'b0, be: '1,
                                   addr: i_addr_i, wdata: '0};
                        state <= ARB_REQ;
                    end else if (d_win) begin
                        owner <= ARB_OWN_D;
                        lat   <= '{we: d_we_i, be: d_be_i,
                                   addr: d_addr_i, wdata: d_wdata_i};
                        state <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (mem_gnt_i) state <= ARB_RSP;
                end
                ARB_RSP: begin
                    if (mem_rvalid_i) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Bus fields only leave the block while a request is presented.
    assign in_req      = (state == ARB_REQ);
    assign gnt         = in_req && mem_gnt_i;
    assign rsp         = (state == ARB_RSP) && mem_rvalid_i;

    assign mem_req_o   = in_req;
    assign mem_we_o    = in_req && lat.we;
    assign mem_be_o    = in_req ? lat.be : '0;
    assign mem_addr_o  = in_req ? lat.addr : '0;
    assign mem_wdata_o = in_req ? lat.wdata : '0;

    assign i_gnt_o     = gnt && (owner == ARB_OWN_I);
    assign d_gnt_o     = gnt && (owner == ARB_OWN_D);
    assign i_rvalid_o  = rsp && (owner == ARB_OWN_I);
    assign d_rvalid_o  = rsp && (owner == ARB_OWN_D);
    assign i_rdata_o   = i_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: doc/kamus_mem_arbiter.md
Name: kamus_mem_arbiter

Overview:
Arbitrates between the core's instruction-fetch port (l1i) and data port (l1d) for one shared single-ported memory bus. It holds at most one memory transaction in flight. Data requests have fixed priority, and a starvation counter guarantees that fetches make forward progress. The block sits between kamus_core and the unified memory/cache model.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_LIMIT, 4, consecutive data wins over a pending fetch before the fetch is forced through (must be ≥1)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  synchronous active-low reset
i_req_i  in  1  fetch request; held high until i_gnt_o
i_addr_i  in  ADDR_W  fetch address
i_gnt_o  out  1  fetch accepted by memory (1-cycle pulse)
i_rvalid_o  out  1  fetch data valid (1-cycle pulse)
i_rdata_o  out  DATA_W  fetch data
d_req_i  in  1  data request; held high until d_gnt_o
d_we_i  in  1  1 = store, 0 = load
d_be_i  in  DATA_W/8  byte enables
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  store data
d_gnt_o  out  1  data request accepted (1-cycle pulse)
d_rvalid_o  out  1  load data / store ack valid (1-cycle pulse)
d_rdata_o  out  DATA_W  load data
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_be_o  out  DATA_W/8  memory byte enables
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_gnt_i  in  1  memory accepts the request this cycle
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, REQ, RSP. An owner register records I or D.
- Reset (synchronous, rst_ni=0 at a clock edge):
  - state goes to IDLE, owner to D, starvation counter to 0.
  - All mem_* outputs are 0. All gnt_o and rvalid_o outputs are 0. rdata_o outputs are 0.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If only one request is high, that requester wins.
  - If both are high, D wins unless the counter equals STARVE_LIMIT, in which case I wins.
  - On a win: latch owner and the winner's addr/we/be/wdata into registers, go to REQ.
  - A fetch always latches we=0 and be=all-ones.
- REQ:
  - mem_req_o=1 and mem_* are driven from the latched registers, stable while waiting.
  - When mem_gnt_i=1, pulse the owner's gnt_o combinationally in that same cycle, then go to RSP.
  - The non-owner's gnt_o stays 0.
- RSP:
  - mem_req_o=0.
  - When mem_rvalid_i=1, drive the owner's rvalid_o=1 and rdata_o=mem_rdata_i combinationally, then go to IDLE.
  - A store also gets an rvalid_o pulse; its rdata content is don't-care.
- Latency:
  - A request first seen high in IDLE at cycle N gives mem_req_o=1 at N+1.
  - With immediate mem_gnt_i and mem_rvalid_i at N+2, rvalid_o fires at N+2 and the FSM is back in IDLE at N+3.
  - Minimum issue interval is therefore 3 cycles.
- Starvation counter:
  - Width is $clog2(STARVE_LIMIT+1).
  - Increments, saturating at STARVE_LIMIT, on each IDLE arbitration where D wins while i_req_i=1.
  - Clears to 0 whenever I wins.
  - Otherwise unchanged.
- Boundaries:
  - mem_rvalid_i in IDLE or REQ is ignored, so a stale response after reset is dropped.
  - mem_gnt_i outside REQ is ignored.
  - A requester that deasserts req after winning but before gnt is still serviced from the latched copy.
  - A new request arriving during REQ/RSP waits for IDLE.
  - Reset mid-transaction abandons the transaction. Neither gnt_o nor rvalid_o is issued for it.
- Unselected rdata_o outputs hold 0.

Decomposition:
- kamus_pkg gains:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RSP} arb_state_e
  - typedef enum logic {ARB_OWN_I, ARB_OWN_D} arb_owner_e
  - struct mem_req_t {we, be, addr, wdata}
- One natural sub-module: kamus_arb_starve_cnt, the saturating counter with inc/clr and an at_limit output.

Test Plan:
1. Fetch only: i_req_i=1, i_addr_i=0x100, mem_gnt_i tied 1, mem_rvalid_i one cycle after gnt with rdata=0x00100093 → mem_addr_o=0x100, mem_we_o=0, i_rvalid_o pulse with i_rdata_o=0x00100093, d_* outputs stay 0.
2. Store: d_req_i=1, d_we_i=1, d_be_i=4'b0011, d_addr_i=0x2, d_wdata_i=0x2 → mem_we_o=1, mem_be_o=4'b0011, mem_addr_o=0x2, mem_wdata_o=0x2, d_gnt_o pulse, then d_rvalid_o pulse.
3. Contention with STARVE_LIMIT=4: both requests held high continuously, immediate gnt/rvalid → grant order D,D,D,D,I,D,D,D,D,I; counter reads 0 after each I grant.
4. Backpressure: mem_gnt_i held 0 for 5 cycles in REQ while d_addr_i changes to 0x40 → mem_addr_o stays at the latched 0x2 with mem_req_o=1 throughout; d_gnt_o pulses only on the cycle mem_gnt_i=1.
5. Reset in RSP: rst_ni=0 for one cycle before mem_rvalid_i, then mem_rvalid_i=1 arrives in IDLE → no rvalid_o pulse, all outputs 0, FSM in IDLE, next request serviced normally.
6. Spurious inputs: mem_rvalid_i=1 and mem_gnt_i=1 pulsed while in IDLE with no requests → no gnt_o or rvalid_o asserted, state remains IDLE.
